mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port round-robin arbiter and sequencer for the CPU's shared 2048x32 single-port data/instruction memory. Port 0 (instruction fetch, read-only) and port 1 (load/store, read or write) each issue req/adrs requests. The block grants at most one access per cycle, drives the memory's enable/write/address/data lines, and routes registered read data back to the owning port with a fixed 2-cycle latency. It sits between the fetch/MEM pipeline stages and the memory array. Reads are fully pipelined at one access per cycle.

## Interface
Parameters:
- ADDR_WIDTH, 11, memory address width (2048 words)
- DATA_WIDTH, 32, memory word width

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  single clock for all logic
- reset  in  1  synchronous, active-high reset
- p0_req  in  1  port 0 read request; held until p0_gnt
- p0_adrs  in  ADDR_WIDTH  port 0 read address
- p0_gnt  out  1  port 0 request accepted this cycle (combinational)
- p0_rvalid  out  1  port 0 read data valid (registered pulse)
- p0_rdata  out  DATA_WIDTH  port 0 read data (registered)
- p1_req  in  1  port 1 request; held until p1_gnt
- p1_we  in  1  port 1: 1 = write, 0 = read
- p1_adrs  in  ADDR_WIDTH  port 1 address
- p1_wdata  in  DATA_WIDTH  port 1 write data
- p1_gnt  out  1  port 1 request accepted this cycle (combinational)
- p1_rvalid  out  1  port 1 read data valid (registered pulse)
- p1_rdata  out  DATA_WIDTH  port 1 read data (registered)
- mem_en  out  1  memory access enable (combinational)
- mem_we  out  1  memory write enable (combinational)
- mem_adrs  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after a read is enabled

## Operation
- Arbitration (combinational, cycle N):
  - Only one requester: it is granted.
  - Both requesting: the port other than `last` is granted.
  - `last` is a 1-bit register, reset to 1, so port 0 wins the first tie.
  - `last` updates to the granted port on every grant and holds when there is no grant.
- p0_gnt and p1_gnt are mutually exclusive. A grant is never asserted without the matching req.
- Memory drive:
  - On grant, mem_en=1, and mem_adrs is taken from the granted port.
  - mem_we = p1_we only when port 1 is granted; otherwise 0.
  - mem_wdata = p1_wdata always.
  - No grant: mem_en=0, mem_we=0.
- Read tracking uses a 2-stage owner pipeline, each stage holding {valid, port}:
  - Stage 1 loads {read granted, port} at the end of N.
  - Stage 2 loads stage 1 at the end of N+1, and p<port>_rdata captures mem_rdata at the same edge.
  - Stage 2 valid drives pX_rvalid in N+2.
- Writes create no stage-1 entry and produce no rvalid; p1_gnt is the only write acknowledgement.
- pX_rdata holds its last captured value between rvalids.
- Requesters must keep req, adrs, we and wdata stable until gnt. The arbiter does not latch request fields.

## Timing
- Read latency: gnt in cycle N, rvalid pulse in N+2 (exactly one cycle per granted read).
- Throughput: one grant per cycle. Back-to-back reads from either or both ports overlap in the owner pipeline without loss or reordering. Responses return in grant order.
- Reset values:
  - p0_rvalid=0, p1_rvalid=0.
  - p0_rdata=0, p1_rdata=0.
  - Both owner stages invalid; last=1.
  - Grant and mem_* outputs depend only on inputs and `last`, so they follow the arbitration rules immediately after reset.
- While reset=1:
  - No grants; mem_en=0, mem_we=0.
  - Any in-flight read is discarded: no rvalid in the two cycles after reset deasserts for grants made before reset.
- Write-then-read: a port 1 write in N followed by a read of the same address in N+1 returns the new data in N+3.
- Addresses wrap naturally in ADDR_WIDTH bits; 0 and 2047 are ordinary addresses.

## Test plan
- Reset then idle: reset high for 2 cycles -> all rvalid=0, rdata=0, mem_en=0. Then p0_req alone at adrs 5 -> p0_gnt the same cycle, p0_rvalid one cycle later by 2 cycles with mem[5].
- Contention fairness: both ports request reads continuously for 8 cycles -> grants alternate 0,1,0,1,…, starting with port 0. Each port gets 4 rvalids, each 2 cycles after its grant, with correct data.
- Write/read ordering: p1 writes 0xDEADBEEF to 2047 -> p1_gnt=1, mem_we=1, no rvalid. Next cycle p0 reads 2047 -> p0_rdata=0xDEADBEEF in N+3.
- Back-to-back pipelining: p1 reads addresses 0,1,2,3 on consecutive cycles -> four consecutive p1_rvalid pulses in order with mem[0..3]. p0_rvalid stays 0 throughout.
- Mixed: p0 read and p1 write requested in the same cycle with last=0 -> p1 wins. The write takes effect, the p0 read is granted next cycle, and exactly one rvalid is produced, on p0.
- Reset mid-flight: grant reads in N and N+1, then assert reset in N+1 -> no p0_rvalid or p1_rvalid in N+2..N+3. last returns to 1.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: both requester ports plus the memory-side lines.
// slave  = arbiter view, master = requester/memory (environment) view.
interface mem_arbiter_if #(
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_WIDTH = 32
);
   // port 0: instruction fetch, read-only
   logic                  p0_req;
   logic [ADDR_WIDTH-1:0] p0_adrs;
   logic                  p0_gnt;
   logic                  p0_rvalid;
   logic [DATA_WIDTH-1:0] p0_rdata;
   // port 1: load/store
   logic                  p1_req;
   logic                  p1_we;
   logic [ADDR_WIDTH-1:0] p1_adrs;
   logic [DATA_WIDTH-1:0] p1_wdata;
   logic                  p1_gnt;
   logic                  p1_rvalid;
   logic [DATA_WIDTH-1:0] p1_rdata;
   // memory side
   logic                  mem_en;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_adrs;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;

   modport slave (
      input  p0_req, p0_adrs,
      output p0_gnt, p0_rvalid, p0_rdata,
      input  p1_req, p1_we, p1_adrs, p1_wdata,
      output p1_gnt, p1_rvalid, p1_rdata,
      output mem_en, mem_we, mem_adrs, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output p0_req, p0_adrs,
      input  p0_gnt, p0_rvalid, p0_rdata,
      output p1_req, p1_we, p1_adrs, p1_wdata,
      input  p1_gnt, p1_rvalid, p1_rdata,
      input  mem_en, mem_we, mem_adrs, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter/sequencer for a shared single-port memory.
// One grant per cycle; read data returns to the owning port 2 cycles after grant.
module mem_arbiter #(
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_WIDTH = 32
) (
   input logic          clk,
   input logic          reset,
   mem_arbiter_if.slave bus
);

   logic                  last_q, last_d;       // port granted most recently (1 = port 1)
   logic                  gnt0, gnt1;
   logic                  rd_gnt;
   logic [ADDR_WIDTH-1:0] adrs_w;

   // read owner pipeline: stage 1 = address cycle, stage 2 = data-return cycle
   logic                  s1_vld_q, s1_vld_d;
   logic                  s1_port_q, s1_port_d;
   logic                  s2_vld_q, s2_vld_d;
   logic                  s2_port_q, s2_port_d;
   logic [DATA_WIDTH-1:0] p0_rdata_q, p0_rdata_d;
   logic [DATA_WIDTH-1:0] p1_rdata_q, p1_rdata_d;

   // Arbitration: single requester wins; on a tie the port other than last wins.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!reset) begin
         if (bus.p0_req && bus.p1_req) begin
            gnt0 = last_q;
            gnt1 = ~last_q;
         end else begin
            gnt0 = bus.p0_req;
            gnt1 = bus.p1_req;
         end
      end
   end

   // Memory address mux: port 1 address only when port 1 holds the grant.
   always_comb begin
      adrs_w = gnt1 ? bus.p1_adrs : bus.p0_adrs;
   end

   assign rd_gnt        = gnt0 | (gnt1 & ~bus.p1_we);
   assign bus.p0_gnt    = gnt0;
   assign bus.p1_gnt    = gnt1;
   assign bus.mem_en    = gnt0 | gnt1;
   assign bus.mem_we    = gnt1 & bus.p1_we;
   assign bus.mem_adrs  = adrs_w;
   assign bus.mem_wdata = bus.p1_wdata;

   // Next-state: fairness pointer, owner pipeline advance, read-data capture.
   always_comb begin
      last_d = last_q;
      if (gnt0 || gnt1) begin
         last_d = gnt1;
      end
      s1_vld_d   = rd_gnt;
      s1_port_d  = gnt1;
      s2_vld_d   = s1_vld_q;
      s2_port_d  = s1_port_q;
      p0_rdata_d = p0_rdata_q;
      p1_rdata_d = p1_rdata_q;
      if (s1_vld_q) begin
         if (s1_port_q) begin
            p1_rdata_d = bus.mem_rdata;
         end else begin
            p0_rdata_d = bus.mem_rdata;
         end
      end
   end

   // State registers; reset flushes in-flight reads and re-arms port 0 priority.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_q     <= 1'b1;
         s1_vld_q   <= 1'b0;
         s1_port_q  <= 1'b0;
         s2_vld_q   <= 1'b0;
         s2_port_q  <= 1'b0;
         p0_rdata_q <= '0;
         p1_rdata_q <= '0;
      end else begin
         last_q     <= last_d;
         s1_vld_q   <= s1_vld_d;
         s1_port_q  <= s1_port_d;
         s2_vld_q   <= s2_vld_d;
         s2_port_q  <= s2_port_d;
         p0_rdata_q <= p0_rdata_d;
         p1_rdata_q <= p1_rdata_d;
      end
   end

   assign bus.p0_rvalid = s2_vld_q & ~s2_port_q;
   assign bus.p1_rvalid = s2_vld_q &  s2_port_q;
   assign bus.p0_rdata  = p0_rdata_q;
   assign bus.p1_rdata  = p1_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: behavioural 2048x32 memory, scoreboard of expected
// read returns (port, data, due cycle) checked by a negedge monitor.
module tb_mem_arbiter;
   localparam int AW = 11;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   logic [DW-1:0] mem_arr [0:2047];
   logic [DW-1:0] ref_mem [0:2047];

   // memory array: registered read, valid the cycle after enable
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) mem_arr[bus.mem_adrs] <= bus.mem_wdata;
         else            bus.mem_rdata <= mem_arr[bus.mem_adrs];
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;
   int rv_cnt0 = 0;
   int rv_cnt1 = 0;

   typedef struct {
      logic          port;
      logic [DW-1:0] data;
      int            due;
   } exp_t;
   exp_t sb[$];

   // monitor: every rvalid must match the scoreboard head; an overdue head is a miss
   always @(negedge clk) begin
      if (bus.p0_rvalid === 1'b1 || bus.p1_rvalid === 1'b1) begin
         checks++;
         if (bus.p0_rvalid === 1'b1) rv_cnt0++;
         if (bus.p1_rvalid === 1'b1) rv_cnt1++;
         if (bus.p0_rvalid === 1'b1 && bus.p1_rvalid === 1'b1) begin
            failures++;
            $display("FAIL rvalid_both: cycle %0d p0_rvalid=1 p1_rvalid=1, want at most one", cyc);
         end else if (sb.size() == 0) begin
            failures++;
            $display("FAIL rvalid_unexpected: cycle %0d p0_rvalid=%b p1_rvalid=%b, want none",
                     cyc, bus.p0_rvalid, bus.p1_rvalid);
         end else begin
            exp_t e;
            logic [DW-1:0] got;
            e   = sb.pop_front();
            got = bus.p1_rvalid ? bus.p1_rdata : bus.p0_rdata;
            if (bus.p1_rvalid !== e.port || got !== e.data || cyc != e.due) begin
               failures++;
               $display("FAIL rvalid_data: cycle %0d port=%b data=%h, want cycle %0d port=%b data=%h",
                        cyc, bus.p1_rvalid, got, e.due, e.port, e.data);
            end
         end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
         exp_t e;
         e = sb.pop_front();
         checks++;
         failures++;
         $display("FAIL rvalid_missing: cycle %0d no rvalid, want port=%b data=%h", cyc, e.port, e.data);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.p0_req   = 1'b0;
      bus.p0_adrs  = '0;
      bus.p1_req   = 1'b0;
      bus.p1_we    = 1'b0;
      bus.p1_adrs  = '0;
      bus.p1_wdata = '0;
   endtask

   task automatic push_read(input logic port, input logic [AW-1:0] adrs);
      exp_t e;
      e.port = port;
      e.data = ref_mem[adrs];
      e.due  = cyc + 2;
      sb.push_back(e);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.p0_req = 1'b1; bus.p0_adrs = 11'd3;
      bus.p1_req = 1'b1; bus.p1_adrs = 11'd4;
      repeat (2) begin
         tick();
         checks++;
         if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0 || bus.p0_gnt !== 1'b0 || bus.p1_gnt !== 1'b0) begin
            failures++;
            $display("FAIL reset_grant: en=%b we=%b g0=%b g1=%b, want all 0",
                     bus.mem_en, bus.mem_we, bus.p0_gnt, bus.p1_gnt);
         end
         checks++;
         if (bus.p0_rvalid !== 1'b0 || bus.p1_rvalid !== 1'b0 || bus.p0_rdata !== '0 || bus.p1_rdata !== '0) begin
            failures++;
            $display("FAIL reset_outputs: rv0=%b rv1=%b rd0=%h rd1=%h, want 0",
                     bus.p0_rvalid, bus.p1_rvalid, bus.p0_rdata, bus.p1_rdata);
         end
      end
      reset = 1'b0;
      clear_inputs();
      bus.p0_req = 1'b1; bus.p0_adrs = 11'd5;
      #1;
      checks++;
      if (bus.p0_gnt !== 1'b1 || bus.p1_gnt !== 1'b0 || bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 ||
          bus.mem_adrs !== 11'd5) begin
         failures++;
         $display("FAIL single_p0: g0=%b g1=%b en=%b we=%b adrs=%0d, want 1 0 1 0 5",
                  bus.p0_gnt, bus.p1_gnt, bus.mem_en, bus.mem_we, bus.mem_adrs);
      end
      push_read(1'b0, 11'd5);
      tick();
      clear_inputs();
      repeat (3) tick();
   endtask

   task automatic test_contention();
      logic [AW-1:0] a0, a1;
      logic          exp_p;
      int            c0, c1;
      reset = 1'b1;
      clear_inputs();
      tick();
      reset = 1'b0;
      c0 = rv_cnt0; c1 = rv_cnt1;
      a0 = 11'd100; a1 = 11'd200;
      bus.p0_req = 1'b1; bus.p1_req = 1'b1;
      for (int k = 0; k < 8; k++) begin
         bus.p0_adrs = a0;
         bus.p1_adrs = a1;
         exp_p = (k % 2 == 1);
         #1;
         checks++;
         if (bus.p0_gnt !== ~exp_p || bus.p1_gnt !== exp_p || bus.mem_adrs !== (exp_p ? a1 : a0)) begin
            failures++;
            $display("FAIL contention_gnt[%0d]: g0=%b g1=%b adrs=%0d, want g0=%b g1=%b adrs=%0d",
                     k, bus.p0_gnt, bus.p1_gnt, bus.mem_adrs, ~exp_p, exp_p, exp_p ? a1 : a0);
         end
         push_read(exp_p, exp_p ? a1 : a0);
         tick();
         if (exp_p) a1 = a1 + 11'd1;
         else       a0 = a0 + 11'd1;
      end
      clear_inputs();
      repeat (3) tick();
      checks++;
      if (rv_cnt0 - c0 != 4 || rv_cnt1 - c1 != 4) begin
         failures++;
         $display("FAIL contention_count: rv0=%0d rv1=%0d, want 4 4", rv_cnt0 - c0, rv_cnt1 - c1);
      end
   endtask

   task automatic test_write_read();
      bus.p1_req = 1'b1; bus.p1_we = 1'b1; bus.p1_adrs = 11'd2047; bus.p1_wdata = 32'hDEADBEEF;
      #1;
      checks++;
      if (bus.p1_gnt !== 1'b1 || bus.p0_gnt !== 1'b0 || bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 ||
          bus.mem_adrs !== 11'd2047 || bus.mem_wdata !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL write_drive: g1=%b g0=%b en=%b we=%b adrs=%0d wd=%h, want 1 0 1 1 2047 deadbeef",
                  bus.p1_gnt, bus.p0_gnt, bus.mem_en, bus.mem_we, bus.mem_adrs, bus.mem_wdata);
      end
      ref_mem[2047] = 32'hDEADBEEF;
      tick();
      clear_inputs();
      bus.p0_req = 1'b1; bus.p0_adrs = 11'd2047;
      #1;
      checks++;
      if (bus.p0_gnt !== 1'b1 || bus.mem_we !== 1'b0) begin
         failures++;
         $display("FAIL wr_rd_gnt: g0=%b we=%b, want 1 0", bus.p0_gnt, bus.mem_we);
      end
      push_read(1'b0, 11'd2047);
      tick();
      clear_inputs();
      repeat (4) tick();
      checks++;
      if (bus.p0_rdata !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL rdata_hold: p0_rdata=%h, want deadbeef", bus.p0_rdata);
      end
   endtask

   task automatic test_back_to_back();
      int c0, c1;
      c0 = rv_cnt0; c1 = rv_cnt1;
      bus.p1_req = 1'b1; bus.p1_we = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.p1_adrs = 11'(i);
         #1;
         checks++;
         if (bus.p1_gnt !== 1'b1 || bus.mem_adrs !== 11'(i)) begin
            failures++;
            $display("FAIL b2b_gnt[%0d]: g1=%b adrs=%0d, want 1 %0d", i, bus.p1_gnt, bus.mem_adrs, i);
         end
         push_read(1'b1, 11'(i));
         tick();
      end
      clear_inputs();
      repeat (3) tick();
      checks++;
      if (rv_cnt1 - c1 != 4 || rv_cnt0 - c0 != 0) begin
         failures++;
         $display("FAIL b2b_count: rv0=%0d rv1=%0d, want 0 4", rv_cnt0 - c0, rv_cnt1 - c1);
      end
   endtask

   task automatic test_mixed();
      int c0, c1;
      c0 = rv_cnt0; c1 = rv_cnt1;
      // port 0 alone first so port 1 wins the following tie
      bus.p0_req = 1'b1; bus.p0_adrs = 11'd20;
      #1;
      push_read(1'b0, 11'd20);
      tick();
      bus.p0_adrs = 11'd7;
      bus.p1_req = 1'b1; bus.p1_we = 1'b1; bus.p1_adrs = 11'd8; bus.p1_wdata = 32'h12345678;
      #1;
      checks++;
      if (bus.p1_gnt !== 1'b1 || bus.p0_gnt !== 1'b0 || bus.mem_we !== 1'b1 || bus.mem_adrs !== 11'd8) begin
         failures++;
         $display("FAIL mixed_tie: g0=%b g1=%b we=%b adrs=%0d, want 0 1 1 8",
                  bus.p0_gnt, bus.p1_gnt, bus.mem_we, bus.mem_adrs);
      end
      ref_mem[8] = 32'h12345678;
      tick();
      bus.p1_req = 1'b0; bus.p1_we = 1'b0;
      #1;
      checks++;
      if (bus.p0_gnt !== 1'b1 || bus.mem_adrs !== 11'd7) begin
         failures++;
         $display("FAIL mixed_p0_next: g0=%b adrs=%0d, want 1 7", bus.p0_gnt, bus.mem_adrs);
      end
      push_read(1'b0, 11'd7);
      tick();
      bus.p0_req = 1'b0;
      bus.p1_req = 1'b1; bus.p1_adrs = 11'd8;
      #1;
      push_read(1'b1, 11'd8);
      tick();
      clear_inputs();
      repeat (3) tick();
      checks++;
      if (rv_cnt0 - c0 != 2 || rv_cnt1 - c1 != 1) begin
         failures++;
         $display("FAIL mixed_count: rv0=%0d rv1=%0d, want 2 1", rv_cnt0 - c0, rv_cnt1 - c1);
      end
   endtask

   task automatic test_reset_midflight();
      bus.p0_req = 1'b1; bus.p0_adrs = 11'd10;
      #1;
      checks++;
      if (bus.p0_gnt !== 1'b1) begin
         failures++;
         $display("FAIL midflight_gnt: g0=%b, want 1", bus.p0_gnt);
      end
      tick();
      reset = 1'b1;
      bus.p0_req = 1'b0;
      bus.p1_req = 1'b1; bus.p1_adrs = 11'd11;
      #1;
      checks++;
      if (bus.p1_gnt !== 1'b0 || bus.mem_en !== 1'b0) begin
         failures++;
         $display("FAIL midflight_reset_gnt: g1=%b en=%b, want 0 0", bus.p1_gnt, bus.mem_en);
      end
      tick();
      reset = 1'b0;
      clear_inputs();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (bus.p0_rvalid !== 1'b0 || bus.p1_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL midflight_flush[%0d]: rv0=%b rv1=%b, want 0 0", i, bus.p0_rvalid, bus.p1_rvalid);
         end
         tick();
      end
      bus.p0_req = 1'b1; bus.p0_adrs = 11'd30;
      bus.p1_req = 1'b1; bus.p1_adrs = 11'd31;
      #1;
      checks++;
      if (bus.p0_gnt !== 1'b1 || bus.p1_gnt !== 1'b0) begin
         failures++;
         $display("FAIL midflight_last: g0=%b g1=%b, want 1 0", bus.p0_gnt, bus.p1_gnt);
      end
      push_read(1'b0, 11'd30);
      tick();
      clear_inputs();
      repeat (3) tick();
   endtask

   initial begin
      for (int unsigned i = 0; i < 2048; i++) begin
         mem_arr[i] = (32'(i) * 32'h9E3779B1) ^ 32'hC3A50000;
         ref_mem[i] = (32'(i) * 32'h9E3779B1) ^ 32'hC3A50000;
      end
      clear_inputs();
      test_reset();
      test_contention();
      test_write_read();
      test_back_to_back();
      test_mixed();
      test_reset_midflight();
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
